// File: rtl/stream_mux_4x1_if.sv
// Handshake bundle for the 4:1 packet stream mux: four input streams plus one
// output stream carrying a 2-bit source tag.
interface stream_mux_4x1_if #(
  parameter int W = 8
);
  logic [3:0]     in_valid;
  logic [3:0]     in_last;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_sel;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/stream_mux_4x1.sv
// Round-robin 4:1 packet stream mux; the grant is held for a whole packet and
// the output is a single registered beat tagged with its source channel.
module stream_mux_4x1 #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    stream_mux_4x1_if.slave  bus,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q;
    logic [1:0]       grant_q;
    logic [1:0]       rr_ptr_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [W-1:0]     out_data_q;
    logic [1:0]       out_sel_q;
    logic             busy_q;
    logic [CNT_W-1:0] pkt_cnt_q;

    logic [1:0]       pick_d;
    logic [1:0]       idx_d;
    logic             found_d;
    logic [3:0]       in_ready_d;
    logic             xfer_d;
    logic [W-1:0]     g_data_d;
    logic             g_last_d;

    // First requester at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        found_d = 1'b0;
        pick_d  = rr_ptr_q;
        idx_d   = rr_ptr_q;
        for (int unsigned i = 0; i < 4; i++) begin
            idx_d = rr_ptr_q + 2'(i);
            if (!found_d && bus.in_valid[idx_d]) begin
                found_d = 1'b1;
                pick_d  = idx_d;
            end
        end
    end

    // Only the granted slice is ever read, so X on other channels stays contained.
    always_comb begin
        in_ready_d = '0;
        if (state_q == BUSY)
            in_ready_d[grant_q] = !out_valid_q || bus.out_ready;
        xfer_d   = (state_q == BUSY) && bus.in_valid[grant_q] && in_ready_d[grant_q];
        g_data_d = bus.in_data[grant_q*W +: W];
        g_last_d = bus.in_last[grant_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            busy_q      <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            if (out_valid_q && bus.out_ready && out_last_q)
                pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);

            if (xfer_d) begin
                out_valid_q <= 1'b1;
                out_data_q  <= g_data_d;
                out_last_q  <= g_last_d;
                out_sel_q   <= grant_q;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_q <= pick_d;
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (xfer_d && g_last_d) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= grant_q + 2'd1;
                        busy_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;
    assign busy          = busy_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule
